// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-requester round-robin arbiter driving the mux2to1 select.
// sel=0 routes requester A, sel=1 routes requester B. A grant lasts until done,
// the owner drops its request, or the hold timeout expires while the other side waits.
// Optional macro GRANT_COUNT_EN adds per-side grant counters cnt_a / cnt_b.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16
`ifdef GRANT_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic sel,
  output logic grant_a,
  output logic grant_b,
  output logic busy
`ifdef GRANT_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  // hold_cnt must be able to hold MAX_HOLD itself, since it saturates there
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD < 1) ? 0 : MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t        state, state_nxt;
  logic          last_b, last_b_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          new_grant;
  logic          hold_expired;
  logic          sel_nxt, grant_a_nxt, grant_b_nxt;

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign busy = grant_a | grant_b;

  // State register plus registered outputs and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
      sel      <= 1'b0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      hold_cnt <= hold_cnt_nxt;
      sel      <= sel_nxt;
      grant_a  <= grant_a_nxt;
      grant_b  <= grant_b_nxt;
    end
  end

  // Next-state: round-robin from IDLE, direct hand-over on exit, reload when only the owner still asks
  always_comb begin
    state_nxt = state;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt = last_b ? GRANT_A : GRANT_B;
          new_grant = 1'b1;
        end else if (req_a) begin
          state_nxt = GRANT_A;
          new_grant = 1'b1;
        end else if (req_b) begin
          state_nxt = GRANT_B;
          new_grant = 1'b1;
        end
      end
      GRANT_A: begin
        if (done || !req_a || (hold_expired && req_b)) begin
          if (req_b) begin
            state_nxt = GRANT_B;
            new_grant = 1'b1;
          end else if (req_a) begin
            state_nxt = GRANT_A;
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GRANT_B: begin
        if (done || !req_b || (hold_expired && req_a)) begin
          if (req_a) begin
            state_nxt = GRANT_A;
            new_grant = 1'b1;
          end else if (req_b) begin
            state_nxt = GRANT_B;
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and bookkeeping values for the next edge; sel keeps its value while idle
  always_comb begin
    sel_nxt      = sel;
    grant_a_nxt  = (state_nxt == GRANT_A);
    grant_b_nxt  = (state_nxt == GRANT_B);
    last_b_nxt   = last_b;
    hold_cnt_nxt = hold_cnt;
    if (state_nxt == GRANT_A) sel_nxt = 1'b0;
    if (state_nxt == GRANT_B) sel_nxt = 1'b1;
    if (new_grant) last_b_nxt = (state_nxt == GRANT_B);
    if ((state_nxt == IDLE) || new_grant) begin
      hold_cnt_nxt = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt_nxt = hold_cnt + 1'b1;
    end
  end

`ifdef GRANT_COUNT_EN
  // Per-side grant counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (new_grant) begin
      if (state_nxt == GRANT_A) cnt_a <= cnt_a + 1'b1;
      if (state_nxt == GRANT_B) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed self-checking bench for mux_sel_arbiter.
// Three instances share the inputs: MAX_HOLD=16 (main), 4 and 0 (preemption).
// With GRANT_COUNT_EN a fourth instance with CNT_W=2 exercises counter wrap.
module tb_mux_sel_arbiter;

  logic clk;
  logic rst, req_a, req_b, done;

  logic sel16, ga16, gb16, busy16;
  logic sel4,  ga4,  gb4,  busy4;
  logic sel0,  ga0,  gb0,  busy0;

  int vectors;
  int miscompares;

`ifdef GRANT_COUNT_EN
  logic [7:0] ca16, cb16, ca4, cb4, ca0, cb0;
  logic       selc, gac, gbc, busyc;
  logic [1:0] cac, cbc;
`endif

  mux_sel_arbiter #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(sel16), .grant_a(ga16), .grant_b(gb16), .busy(busy16)
`ifdef GRANT_COUNT_EN
    , .cnt_a(ca16), .cnt_b(cb16)
`endif
  );

  mux_sel_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(sel4), .grant_a(ga4), .grant_b(gb4), .busy(busy4)
`ifdef GRANT_COUNT_EN
    , .cnt_a(ca4), .cnt_b(cb4)
`endif
  );

  mux_sel_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(sel0), .grant_a(ga0), .grant_b(gb0), .busy(busy0)
`ifdef GRANT_COUNT_EN
    , .cnt_a(ca0), .cnt_b(cb0)
`endif
  );

`ifdef GRANT_COUNT_EN
  mux_sel_arbiter #(.MAX_HOLD(16), .CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .done(done),
    .sel(selc), .grant_a(gac), .grant_b(gbc), .busy(busyc),
    .cnt_a(cac), .cnt_b(cbc)
  );
`endif

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic a, input logic b, input logic d);
    rst   = r;
    req_a = a;
    req_b = b;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkMain(input string tag, input logic s, input logic a, input logic b);
    checkOutput({tag, ".sel"},     8'(sel16),  8'(s));
    checkOutput({tag, ".grant_a"}, 8'(ga16),   8'(a));
    checkOutput({tag, ".grant_b"}, 8'(gb16),   8'(b));
    checkOutput({tag, ".busy"},    8'(busy16), 8'(a | b));
  endtask

  // Linear sequence of directed steps
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done = 1'b0;

    // Reset held for two cycles, then released with no requests
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkMain("reset", 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkMain("idle_after_reset", 0, 0, 0);
`ifdef GRANT_COUNT_EN
    checkOutput("reset.cnt_a", ca16, 8'd0);
    checkOutput("reset.cnt_b", cb16, 8'd0);
`endif

    // Tie from IDLE: A wins first, done at cycle 5 hands straight to B
    applyStimulus(0, 1, 1, 0);
    checkMain("tie_c1", 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkMain("tie_c2", 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkMain("tie_c3", 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkMain("tie_c4", 0, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkMain("tie_done_rotate", 1, 0, 1);

    // B alone for three cycles, then idle with sel still 1
    applyStimulus(1, 0, 0, 0);
    checkMain("reset2", 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkMain("b_only_c1", 1, 0, 1);
    applyStimulus(0, 0, 1, 0);
    checkMain("b_only_c2", 1, 0, 1);
    applyStimulus(0, 0, 1, 0);
    checkMain("b_only_c3", 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkMain("b_release_idle", 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkMain("idle_sel_hold_done_ignored", 1, 0, 0);

    // Preemption: A granted, B raised two cycles later, no done
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pre_g0.h4.grant_a", 8'(ga4), 8'd1);
    checkOutput("pre_g0.h0.grant_a", 8'(ga0), 8'd1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pre_g1.h4.grant_a", 8'(ga4), 8'd1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("pre_g2.h4.grant_a", 8'(ga4), 8'd1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("pre_g3.h4.grant_a", 8'(ga4), 8'd1);
    checkOutput("pre_g3.h4.grant_b", 8'(gb4), 8'd0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("pre_g4.h4.grant_a", 8'(ga4), 8'd0);
    checkOutput("pre_g4.h4.grant_b", 8'(gb4), 8'd1);
    checkOutput("pre_g4.h4.sel",     8'(sel4), 8'd1);
    checkOutput("pre_g4.h0.grant_a", 8'(ga0), 8'd1);
    checkOutput("pre_g4.h16.grant_a", 8'(ga16), 8'd1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("pre_g5.h4.grant_b", 8'(gb4), 8'd1);
    for (int i = 6; i <= 12; i++) begin
      applyStimulus(0, 1, 1, 0);
      checkOutput($sformatf("pre_g%0d.h0.grant_a", i), 8'(ga0), 8'd1);
      checkOutput($sformatf("pre_g%0d.h0.grant_b", i), 8'(gb0), 8'd0);
    end

    // Reset in the middle of a B grant, then a tie goes to A
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkMain("midrst_grant_b", 1, 0, 1);
    applyStimulus(1, 1, 1, 0);
    checkMain("midrst_applied", 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkMain("midrst_tie_a_first", 0, 1, 0);

`ifdef GRANT_COUNT_EN
    // Counter wrap at CNT_W=2: five A grants via done reloads leaves cnt_a=1
    applyStimulus(1, 0, 0, 0);
    checkOutput("cnt.reset.cnt_a", 8'(cac), 8'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("cnt.g1.cnt_a", 8'(cac), 8'd1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("cnt.g2.cnt_a", 8'(cac), 8'd2);
    checkOutput("cnt.g2.grant_a", 8'(gac), 8'd1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("cnt.g3.cnt_a", 8'(cac), 8'd3);
    applyStimulus(0, 1, 0, 1);
    checkOutput("cnt.g4.cnt_a", 8'(cac), 8'd0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("cnt.g5.cnt_a", 8'(cac), 8'd1);
    checkOutput("cnt.g5.cnt_b", 8'(cbc), 8'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("cnt.hold.cnt_a", 8'(cac), 8'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
